// File: rtl/banner_pkg.sv
// banner_pkg: shared constants for the scrolling banner generator.
//   SCALE_*         glyph scale selector codes (1x/2x/4x/8x)
//   ASCII_SPACE     power-up content of the message buffer
//   GLYPH_W/H       font cell geometry (8x16) and their log2 forms
//   offset_width()  width of the scroll offset for a given buffer size
package banner_pkg;

  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;
  localparam logic [1:0] SCALE_8X = 2'd3;

  localparam logic [6:0] ASCII_SPACE = 7'h20;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int GLYPH_W_LOG2 = 3;
  localparam int GLYPH_H_LOG2 = 4;

  // Longest virtual line is the whole message at 8x scale, so the offset
  // needs msg_len_log2 + log2(glyph width) + log2(max scale) bits.
  function automatic int offset_width(input int msg_len_log2);
    return msg_len_log2 + GLYPH_W_LOG2 + int'(SCALE_8X);
  endfunction

endpackage

// File: rtl/scroll_offset_ctrl.sv
// scroll_offset_ctrl: owns the horizontal scroll position of the banner.
// Detects the per-frame tick, divides it by speed_sel+1, and steps the
// offset left or right, wrapping at the current virtual line length.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pixel_x, pixel_y    raster position (tick at x==0, y==TICK_LINE)
//   scale_sel           glyph scale; any change clears offset and divider
//   speed_sel           advance every speed_sel+1 frames
//   dir, pause          0=left / 1=right, freeze scrolling
//   offset              current scroll offset in pixels
module scroll_offset_ctrl
  import banner_pkg::*;
#(
  parameter int MSG_LEN_LOG2 = 5,
  parameter int TICK_LINE    = 500,
  parameter int OFS_W        = offset_width(MSG_LEN_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic [1:0]       scale_sel,
  input  logic [1:0]       speed_sel,
  input  logic             dir,
  input  logic             pause,
  output logic [OFS_W-1:0] offset
);

  localparam logic [9:0] TICK_Y = 10'(TICK_LINE);

  logic             frame_tick;
  logic             scale_changed;
  logic             divider_wrap;
  logic             advance;
  logic [1:0]       scale_prev;
  logic [1:0]       divider;
  logic [OFS_W-1:0] wrap_mask;
  logic [OFS_W-1:0] offset_next;

  // Tick/advance decode and the wrapped next offset. The divider wraps on
  // ">=" so a speed change landing on a tick still produces an advance
  // rather than counting past the new limit.
  always_comb begin
    frame_tick    = (pixel_x == 10'd0) && (pixel_y == TICK_Y);
    scale_changed = (scale_sel != scale_prev);
    divider_wrap  = (divider >= speed_sel);
    advance       = frame_tick && !pause && divider_wrap;
    wrap_mask     = OFS_W'((1 << (MSG_LEN_LOG2 + GLYPH_W_LOG2 + int'(scale_sel))) - 1);
    if (dir) begin
      offset_next = (offset - OFS_W'(1)) & wrap_mask;
    end else begin
      offset_next = (offset + OFS_W'(1)) & wrap_mask;
    end
  end

  // A scale change restarts scrolling from the left edge and wins over any
  // coincident advance; otherwise the divider counts unpaused ticks and is
  // pulled back to zero if a smaller speed_sel leaves it out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset     <= '0;
      divider    <= 2'd0;
      scale_prev <= SCALE_1X;
    end else begin
      scale_prev <= scale_sel;
      if (scale_changed) begin
        offset  <= '0;
        divider <= 2'd0;
      end else begin
        if (advance) begin
          offset <= offset_next;
        end
        if (frame_tick && !pause) begin
          divider <= divider_wrap ? 2'd0 : divider + 2'd1;
        end else if (divider > speed_sel) begin
          divider <= 2'd0;
        end
      end
    end
  end

endmodule

// File: rtl/scroll_banner_gen.sv
// scroll_banner_gen: pixel-smooth scrolling text banner.
// Maps the raster position plus scroll offset onto a host-written message,
// addresses the shared 8x16 font ROM and registers the resulting colour.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pixel_x, pixel_y    raster position from the sync controller
//   video_on            active video
//   scale_sel           glyph scale 2^scale_sel
//   speed_sel, dir      scroll rate (frames per step - 1) and direction
//   pause               freeze scrolling
//   wr_en/addr/char     message buffer write port
//   rom_addr, rom_data  font ROM address (comb) and row data (next cycle)
//   rgb                 registered 3-bit colour, 2 cycles after the pixel
//   offset              current scroll offset (status)
module scroll_banner_gen
  import banner_pkg::*;
#(
  parameter int         MSG_LEN_LOG2 = 5,
  parameter int         ROW_Y        = 224,
  parameter int         TICK_LINE    = 500,
  parameter logic [2:0] FG           = 3'b111,
  parameter logic [2:0] BG           = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    video_on,
  input  logic [1:0]              scale_sel,
  input  logic [1:0]              speed_sel,
  input  logic                    dir,
  input  logic                    pause,
  input  logic                    wr_en,
  input  logic [MSG_LEN_LOG2-1:0] wr_addr,
  input  logic [6:0]              wr_char,
  output logic [10:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic [2:0]              rgb,
  output logic [MSG_LEN_LOG2+5:0] offset
);

  localparam int         OFS_W   = offset_width(MSG_LEN_LOG2);
  localparam int         MSG_LEN = 1 << MSG_LEN_LOG2;
  localparam int         SUM_W   = ((OFS_W > 10) ? OFS_W : 10) + 1;
  localparam logic [9:0] ROW_TOP = 10'(ROW_Y);

  // Buffer is deliberately outside reset so the host message survives it.
  logic [6:0] msg_ram [MSG_LEN] = '{default: ASCII_SPACE};

  logic [SUM_W-1:0]        x_sum;
  logic [OFS_W-1:0]        wrap_mask;
  logic [OFS_W-1:0]        vx;
  logic [MSG_LEN_LOG2-1:0] char_idx;
  logic [2:0]              column;
  logic [9:0]              dy;
  logic [10:0]             band_h;
  logic                    in_band;
  logic [3:0]              glyph_row;
  logic [6:0]              cur_char;
  logic [2:0]              column_d;
  logic                    text_on_d;
  logic                    video_on_d;
  logic                    pixel_bit;

  scroll_offset_ctrl #(
    .MSG_LEN_LOG2 (MSG_LEN_LOG2),
    .TICK_LINE    (TICK_LINE),
    .OFS_W        (OFS_W)
  ) u_offset_ctrl (
    .clk       (clk),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .scale_sel (scale_sel),
    .speed_sel (speed_sel),
    .dir       (dir),
    .pause     (pause),
    .offset    (offset)
  );

  // Host writes land on the next edge; the combinational read below still
  // sees the old character during a same-slot write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      msg_ram[wr_addr] <= wr_char;
    end
  end

  // Address generation. The virtual line length is a power of two, so the
  // wrap is a mask and character/column/row fall out of shifts by the scale.
  always_comb begin
    x_sum     = SUM_W'(pixel_x) + SUM_W'(offset);
    wrap_mask = OFS_W'((1 << (MSG_LEN_LOG2 + GLYPH_W_LOG2 + int'(scale_sel))) - 1);
    vx        = OFS_W'(x_sum) & wrap_mask;
    char_idx  = MSG_LEN_LOG2'(vx >> (GLYPH_W_LOG2 + int'(scale_sel)));
    column    = 3'(vx >> scale_sel);
    dy        = pixel_y - ROW_TOP;
    band_h    = 11'(GLYPH_H) << scale_sel;
    in_band   = (pixel_y >= ROW_TOP) && ({1'b0, dy} < band_h);
    glyph_row = 4'(dy >> scale_sel);
    cur_char  = msg_ram[char_idx];
    rom_addr  = in_band ? {cur_char, glyph_row} : 11'd0;
  end

  // Column is counted from the left, while the ROM row has its leftmost
  // pixel in the MSB.
  always_comb begin
    pixel_bit = rom_data[3'd7 - column_d];
  end

  // One stage of alignment with the ROM latency, then the colour register.
  always_ff @(posedge clk) begin
    if (rst) begin
      column_d   <= 3'd0;
      text_on_d  <= 1'b0;
      video_on_d <= 1'b0;
      rgb        <= 3'd0;
    end else begin
      column_d   <= column;
      text_on_d  <= in_band;
      video_on_d <= video_on;
      if (!video_on_d) begin
        rgb <= 3'd0;
      end else if (text_on_d) begin
        rgb <= pixel_bit ? FG : BG;
      end else begin
        rgb <= 3'd0;
      end
    end
  end

endmodule
